// File: rtl/dma_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : dma_arbiter_rr
// Purpose  : Stream arbiter for the AHB DMA master port. Picks one of numb_ch
//            streams by 2-bit priority level (3 = highest), breaks ties
//            round-robin, and holds the grant until a beat boundary says
//            otherwise. Every hand-over passes through an idle cycle.
// Ports    : i_clk, i_nreset        clock, asynchronous active-low reset
//            i_en_stream[ch]        stream enabled
//            i_pl[ch]               stream priority level
//            i_relevance_req        1 = peripheral request needed to compete
//            i_requests[ch]         peripheral request per stream
//            i_left_bytes[ch]       bytes still to move (0 = nothing to do)
//            i_master_ready         master idle, can take a new stream
//            i_beat_done            selected stream finished a beat
//            i_burst_last           marks i_beat_done as end of burst
//            o_stream_sel           granted stream index
//            o_master_en            master may transfer for o_stream_sel
//            o_switch               pulse on the first cycle of a new grant
// Options  : DMA_ARB_QUANTUM_EN     limit a grant to max_beats beats while an
//                                   equal-or-higher priority stream waits
// Revision : 1.0  initial release
// ============================================================================
module dma_arbiter_rr #(
  parameter int numb_ch   = 8,
  parameter int fifo_size = 5,
  parameter int max_beats = 16
) (
  input  logic                       i_clk,
  input  logic                       i_nreset,
  input  logic [numb_ch-1:0]         i_en_stream,
  input  logic [1:0]                 i_pl         [numb_ch],
  input  logic                       i_relevance_req,
  input  logic [numb_ch-1:0]         i_requests,
  input  logic [fifo_size:0]         i_left_bytes [numb_ch],
  input  logic                       i_master_ready,
  input  logic                       i_beat_done,
  input  logic                       i_burst_last,
  output logic [$clog2(numb_ch)-1:0] o_stream_sel,
  output logic                       o_master_en,
  output logic                       o_switch
);

  localparam int SEL_W = $clog2(numb_ch);
  localparam logic [SEL_W:0]   c_numb_ch = (SEL_W+1)'(numb_ch);
  localparam logic [SEL_W-1:0] c_last_ch = SEL_W'(numb_ch - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WORK = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SEL_W-1:0]   r_sel;
  logic [SEL_W-1:0]   r_last;
  logic               r_switch;

  logic [numb_ch-1:0] w_elig;
  logic [1:0]         w_max_pl;
  logic               w_win_vld;
  logic [SEL_W-1:0]   w_win;
  logic [SEL_W:0]     w_sum;
  logic [SEL_W-1:0]   w_idx;
  logic               w_cur_elig;
  logic [1:0]         w_cur_pl;
  logic               w_hi_other;
  logic               w_ge_other;
  logic               w_quantum_exit;
  logic               w_exit;
  logic               w_grant;

  // --------------------------------------------------------------------------
  // Eligibility and winner selection
  // --------------------------------------------------------------------------
  always_comb begin
    w_elig    = '0;
    w_max_pl  = 2'd0;
    w_win_vld = 1'b0;
    w_win     = '0;
    w_sum     = '0;
    w_idx     = '0;
    for (int ch = 0; ch < numb_ch; ch++) begin
      w_elig[ch] = i_en_stream[ch] & (|i_left_bytes[ch]) &
                   (i_requests[ch] | ~i_relevance_req);
      if (w_elig[ch] && (i_pl[ch] > w_max_pl)) begin
        w_max_pl = i_pl[ch];
      end
    end
    // Search starts one past the last grant and wraps; k = numb_ch revisits
    // the last granted stream so it still wins when it is alone.
    for (int k = 1; k <= numb_ch; k++) begin
      w_sum = {1'b0, r_last} + (SEL_W+1)'(k);
      if (w_sum >= c_numb_ch) begin
        w_sum = w_sum - c_numb_ch;
      end
      w_idx = w_sum[SEL_W-1:0];
      for (int ch = 0; ch < numb_ch; ch++) begin
        if (!w_win_vld && (SEL_W'(ch) == w_idx) && w_elig[ch] &&
            (i_pl[ch] == w_max_pl)) begin
          w_win_vld = 1'b1;
          w_win     = w_idx;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Status of the currently selected stream and its competitors
  // --------------------------------------------------------------------------
  always_comb begin
    w_cur_elig = 1'b0;
    w_cur_pl   = 2'd0;
    w_hi_other = 1'b0;
    w_ge_other = 1'b0;
    for (int ch = 0; ch < numb_ch; ch++) begin
      if (SEL_W'(ch) == r_sel) begin
        w_cur_elig = w_elig[ch];
        w_cur_pl   = i_pl[ch];
      end
    end
    for (int ch = 0; ch < numb_ch; ch++) begin
      if ((SEL_W'(ch) != r_sel) && w_elig[ch]) begin
        if (i_pl[ch] > w_cur_pl) begin
          w_hi_other = 1'b1;
        end
        if (i_pl[ch] >= w_cur_pl) begin
          w_ge_other = 1'b1;
        end
      end
    end
  end

`ifdef DMA_ARB_QUANTUM_EN
  localparam int BC_W = (max_beats > 1) ? $clog2(max_beats) : 1;
  localparam logic [BC_W-1:0] c_cnt_max = BC_W'(max_beats - 1);

  logic [BC_W-1:0] r_beat_cnt;

  // Quantum only ends a grant when someone at least as important is waiting;
  // otherwise the counter stays saturated and the grant continues.
  assign w_quantum_exit = i_beat_done & (r_beat_cnt == c_cnt_max) & w_ge_other;

  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      r_beat_cnt <= '0;
    end else if (w_grant) begin
      r_beat_cnt <= '0;
    end else if ((r_state == ST_WORK) && i_beat_done &&
                 (r_beat_cnt != c_cnt_max)) begin
      r_beat_cnt <= r_beat_cnt + 1'b1;
    end
  end
`else
  assign w_quantum_exit = 1'b0;
`endif

  if ((numb_ch < 2) || (max_beats < 1)) begin : g_cfg_check
    $error("dma_arbiter_rr: numb_ch must be >= 2 and max_beats >= 1");
  end

  // Ineligibility exits without waiting for a beat; the rest are beat
  // boundary events.
  assign w_exit  = ~w_cur_elig | (i_beat_done & i_burst_last) |
                   (i_beat_done & w_hi_other) | w_quantum_exit;
  assign w_grant = (r_state == ST_IDLE) & w_win_vld & i_master_ready;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_master_en = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant) begin
          w_state_nxt = ST_WORK;
        end
      end
      ST_WORK: begin
        o_master_en = 1'b1;
        if (w_exit) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Grant registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      r_sel    <= '0;
      r_last   <= c_last_ch;
      r_switch <= 1'b0;
    end else begin
      r_switch <= w_grant;
      if (w_grant) begin
        r_sel  <= w_win;
        r_last <= w_win;
      end
    end
  end

  assign o_stream_sel = r_sel;
  assign o_switch     = r_switch;

endmodule
`default_nettype wire

// File: tb/tb_dma_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_arbiter_rr
// Purpose  : Directed, table-driven checks of dma_arbiter_rr (8 streams,
//            max_beats = 4) plus hand-written multi-cycle sequences for
//            asynchronous reset and the beat quantum.
// Revision : 1.0  initial release
// ============================================================================
module tb_dma_arbiter_rr;

  localparam int NCH = 8;

  logic           clk;
  logic           rst_n;
  logic [NCH-1:0] en;
  logic [1:0]     pl   [NCH];
  logic           rel;
  logic [NCH-1:0] req;
  logic [5:0]     left [NCH];
  logic           rdy, bd, bl;
  logic [2:0]     sel;
  logic           men, sw;

  int checks   = 0;
  int failures = 0;

  dma_arbiter_rr #(
    .numb_ch   (NCH),
    .fifo_size (5),
    .max_beats (4)
  ) dut (
    .i_clk           (clk),
    .i_nreset        (rst_n),
    .i_en_stream     (en),
    .i_pl            (pl),
    .i_relevance_req (rel),
    .i_requests      (req),
    .i_left_bytes    (left),
    .i_master_ready  (rdy),
    .i_beat_done     (bd),
    .i_burst_last    (bl),
    .o_stream_sel    (sel),
    .o_master_en     (men),
    .o_switch        (sw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  en;
    logic [7:0]  left;
    logic [15:0] pl;
    logic        rel;
    logic [7:0]  req;
    logic        rdy;
    logic        bd;
    logic        bl;
    logic [2:0]  sel;
    logic        men;
    logic        sw;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [7:0] e, logic [7:0] l, logic [15:0] p,
                              logic r, logic [7:0] q, logic rd, logic b,
                              logic bla, logic [2:0] s, logic m, logic w);
    vec_t v;
    v.en = e; v.left = l; v.pl = p; v.rel = r; v.req = q; v.rdy = rd;
    v.bd = b; v.bl = bla; v.sel = s; v.men = m; v.sw = w;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    en  = v.en;
    rel = v.rel;
    req = v.req;
    rdy = v.rdy;
    bd  = v.bd;
    bl  = v.bl;
    for (int c = 0; c < NCH; c++) begin
      pl[c]   = v.pl[2*c +: 2];
      left[c] = v.left[c] ? 6'd8 : 6'd0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input int idx, input int s,
                         input int m, input int w);
    chk({nm, "_sel"}, idx, int'(sel), s);
    chk({nm, "_en"},  idx, int'(men), m);
    chk({nm, "_sw"},  idx, int'(sw),  w);
  endtask

  vec_t v;

  initial begin
    rst_n = 1'b0;
    apply(mk(8'h00, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0));
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---------------- table: {inputs, expected outputs after the edge} -----
    // Round-robin ch0/1/3 at pl=1, single-beat bursts: 0,1,3,0,1 with idle gaps
    tbl.push_back(mk(8'h0B, 8'h0B, 16'h5555, 0, 8'h00, 1, 0, 0, 3'd0, 1, 1));
    tbl.push_back(mk(8'h0B, 8'h0B, 16'h5555, 0, 8'h00, 1, 1, 1, 3'd0, 0, 0));
    tbl.push_back(mk(8'h0B, 8'h0B, 16'h5555, 0, 8'h00, 1, 0, 0, 3'd1, 1, 1));
    tbl.push_back(mk(8'h0B, 8'h0B, 16'h5555, 0, 8'h00, 1, 1, 1, 3'd1, 0, 0));
    tbl.push_back(mk(8'h0B, 8'h0B, 16'h5555, 0, 8'h00, 1, 0, 0, 3'd3, 1, 1));
    tbl.push_back(mk(8'h0B, 8'h0B, 16'h5555, 0, 8'h00, 1, 1, 1, 3'd3, 0, 0));
    tbl.push_back(mk(8'h0B, 8'h0B, 16'h5555, 0, 8'h00, 1, 0, 0, 3'd0, 1, 1));
    tbl.push_back(mk(8'h0B, 8'h0B, 16'h5555, 0, 8'h00, 1, 1, 1, 3'd0, 0, 0));
    tbl.push_back(mk(8'h0B, 8'h0B, 16'h5555, 0, 8'h00, 1, 0, 0, 3'd1, 1, 1));
    tbl.push_back(mk(8'h0B, 8'h0B, 16'h5555, 0, 8'h00, 1, 1, 1, 3'd1, 0, 0));
    // Master not ready: hold; then ready -> next in rotation (ch3)
    tbl.push_back(mk(8'h0B, 8'h0B, 16'h5555, 0, 8'h00, 0, 0, 0, 3'd1, 0, 0));
    tbl.push_back(mk(8'h0B, 8'h0B, 16'h5555, 0, 8'h00, 1, 0, 0, 3'd3, 1, 1));
    tbl.push_back(mk(8'h0B, 8'h0B, 16'h5555, 0, 8'h00, 1, 1, 1, 3'd3, 0, 0));
    // Single stream ch2: grant, mid-burst beat keeps it, burst end releases
    tbl.push_back(mk(8'h04, 8'h04, 16'h0000, 0, 8'h00, 1, 0, 0, 3'd2, 1, 1));
    tbl.push_back(mk(8'h04, 8'h04, 16'h0000, 0, 8'h00, 1, 1, 0, 3'd2, 1, 0));
    tbl.push_back(mk(8'h04, 8'h04, 16'h0000, 0, 8'h00, 1, 1, 1, 3'd2, 0, 0));
    tbl.push_back(mk(8'h00, 8'h00, 16'h0000, 0, 8'h00, 1, 0, 0, 3'd2, 0, 0));
    // Relevance: no request -> no grant; request -> grant; bytes gone -> exit
    tbl.push_back(mk(8'h02, 8'h02, 16'h0000, 1, 8'h00, 1, 0, 0, 3'd2, 0, 0));
    tbl.push_back(mk(8'h02, 8'h02, 16'h0000, 1, 8'h02, 1, 0, 0, 3'd1, 1, 1));
    tbl.push_back(mk(8'h02, 8'h00, 16'h0000, 1, 8'h02, 1, 0, 0, 3'd1, 0, 0));
    tbl.push_back(mk(8'h00, 8'h00, 16'h0000, 0, 8'h00, 1, 0, 0, 3'd1, 0, 0));
    // Preemption: ch0 pl0 working, ch5 pl3 arrives; exit only at next beat
    tbl.push_back(mk(8'h01, 8'h01, 16'h0000, 0, 8'h00, 1, 0, 0, 3'd0, 1, 1));
    tbl.push_back(mk(8'h21, 8'h21, 16'h0C00, 0, 8'h00, 1, 0, 0, 3'd0, 1, 0));
    tbl.push_back(mk(8'h21, 8'h21, 16'h0C00, 0, 8'h00, 1, 1, 0, 3'd0, 0, 0));
    tbl.push_back(mk(8'h21, 8'h21, 16'h0C00, 0, 8'h00, 1, 0, 0, 3'd5, 1, 1));
    tbl.push_back(mk(8'h21, 8'h21, 16'h0C00, 0, 8'h00, 1, 1, 0, 3'd5, 1, 0));
    tbl.push_back(mk(8'h00, 8'h00, 16'h0000, 0, 8'h00, 1, 1, 1, 3'd5, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      step();
      chk_out("tbl", i, int'(tbl[i].sel), int'(tbl[i].men), int'(tbl[i].sw));
    end

    // ---------------- asynchronous reset mid-grant ---------------------------
    apply(mk(8'h02, 8'h02, 16'h0000, 0, 8'h00, 1, 0, 0, 3'd0, 0, 0));
    step();
    chk_out("pre_rst", 0, 1, 1, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 0, 0, 0, 0);
    // ch0 and ch1 at pl=2 while in reset; pointer restarts so ch0 wins
    apply(mk(8'h03, 8'h03, 16'h000A, 0, 8'h00, 1, 0, 0, 3'd0, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_out("post_rst", 0, 0, 1, 1);

`ifdef DMA_ARB_QUANTUM_EN
    // ---------------- quantum: exactly 4 beats per grant, 0,1,0 --------------
    for (int g = 0; g < 2; g++) begin
      for (int i = 1; i <= 4; i++) begin
        v = mk(8'h03, 8'h03, 16'h000A, 0, 8'h00, 1, 1, 0, 3'd0, 0, 0);
        apply(v);
        step();
        chk("q_en", g * 4 + i, int'(men), (i < 4) ? 1 : 0);
        chk("q_sel", g * 4 + i, int'(sel), g);
      end
      apply(mk(8'h03, 8'h03, 16'h000A, 0, 8'h00, 1, 0, 0, 3'd0, 0, 0));
      step();
      chk_out("q_next", g, (g == 0) ? 1 : 0, 1, 1);
    end
    // ch1 gone: ch0 keeps going past the quantum
    for (int i = 1; i <= 6; i++) begin
      apply(mk(8'h01, 8'h01, 16'h000A, 0, 8'h00, 1, 1, 0, 3'd0, 0, 0));
      step();
      chk_out("q_alone", i, 0, 1, 0);
    end
    apply(mk(8'h01, 8'h01, 16'h000A, 0, 8'h00, 1, 1, 1, 3'd0, 0, 0));
    step();
    chk_out("q_end", 0, 0, 0, 0);
`else
    // ---------------- no quantum: equal-priority peer cannot take over -------
    for (int i = 1; i <= 6; i++) begin
      apply(mk(8'h03, 8'h03, 16'h000A, 0, 8'h00, 1, 1, 0, 3'd0, 0, 0));
      step();
      chk_out("nq_hold", i, 0, 1, 0);
    end
    apply(mk(8'h03, 8'h03, 16'h000A, 0, 8'h00, 1, 1, 1, 3'd0, 0, 0));
    step();
    chk_out("nq_end", 0, 0, 0, 0);
    apply(mk(8'h03, 8'h03, 16'h000A, 0, 8'h00, 1, 0, 0, 3'd0, 0, 0));
    step();
    chk_out("nq_next", 0, 1, 1, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
